// File: rtl/lcd_pkg.sv
// Constants, types and address helpers for the HD44780-style LCD responder and driver.
package lcd_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;

  localparam logic [7:0] OP_SET_DDRAM    = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM    = 8'h40;
  localparam logic [7:0] OP_FUNCTION_SET = 8'h20;
  localparam logic [7:0] OP_SHIFT        = 8'h10;
  localparam logic [7:0] OP_DISPLAY_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY_MODE   = 8'h04;
  localparam logic [7:0] OP_HOME         = 8'h02;
  localparam logic [7:0] OP_CLEAR        = 8'h01;

  localparam logic [6:0] LINE0_BASE    = 7'h00;
  localparam logic [6:0] LINE1_BASE    = 7'h40;
  localparam logic [6:0] LINE_LEN      = 7'd40;
  localparam logic [6:0] LINE0_LAST    = LINE0_BASE + LINE_LEN - 7'd1;
  localparam logic [6:0] LINE1_LAST    = LINE1_BASE + LINE_LEN - 7'd1;
  localparam logic [6:0] VISIBLE_CELLS = 7'd80;
  localparam logic [7:0] BLANK_CHAR    = 8'h20;

  localparam int unsigned DDRAM_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR,
    ST_BUSY
  } lcd_state_t;

  typedef struct packed {
    logic display_on;
    logic cursor_on;
    logic blink_on;
    logic two_line;
    logic eight_bit;
    logic inc_mode;
  } lcd_mode_t;

  localparam lcd_mode_t MODE_RESET = '{display_on: 1'b0, cursor_on: 1'b0, blink_on: 1'b0,
                                       two_line: 1'b0, eight_bit: 1'b1, inc_mode: 1'b1};

  function automatic int unsigned cycles_250ns(input int unsigned freq);
    return freq / 32'd4_000_000;
  endfunction

  function automatic int unsigned cycles_40us(input int unsigned freq);
    return freq / 32'd25_000;
  endfunction

  // Divide first so 41x the 40 us count cannot overflow 32 bits.
  function automatic int unsigned cycles_1640us(input int unsigned freq);
    return (freq / 32'd25_000) * 32'd41;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= LINE0_LAST) || ((a >= LINE1_BASE) && (a <= LINE1_LAST));
  endfunction

  // The two lines form one 80-cell ring: end of line 0 continues on line 1 and back.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == LINE0_LAST) return LINE1_BASE;
      if (a == LINE1_LAST) return LINE0_BASE;
      return a + 7'd1;
    end
    if (a == LINE1_BASE) return LINE0_LAST;
    if (a == LINE0_BASE) return LINE1_LAST;
    return a - 7'd1;
  endfunction

  function automatic logic [6:0] clear_addr(input logic [6:0] idx);
    return (idx < LINE_LEN) ? (LINE0_BASE + idx) : (LINE1_BASE + idx - LINE_LEN);
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display data RAM: one synchronous write port, one registered read port.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:DDRAM_DEPTH-1];

  // Read samples the pre-write contents on a same-address collision.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_responder.sv
// Behavioural HD44780 responder: latches transfers on E falling edge and emulates busy timing.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned D_250ns  = cycles_250ns(CLK_FREQ),
  parameter int unsigned D_40us   = cycles_40us(CLK_FREQ),
  parameter int unsigned D_1640us = cycles_1640us(CLK_FREQ)
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       rs,
  input  logic       e,
  input  logic [7:0] d,
  output logic       busy,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       eight_bit,
  output logic       inc_mode,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       protocol_error
);

  lcd_state_t  state, state_n;
  lcd_mode_t   mode, mode_n;
  logic        e_q, fall, short_pulse;
  logic [31:0] hi_cnt, cnt, cnt_n, busy_limit;
  logic [6:0]  ac_n;
  logic        err_n;
  logic        cmd_rs, cmd_rs_n;
  logic [7:0]  cmd_d, cmd_d_n;
  logic        long_delay, long_delay_n;
  logic        we;
  logic [6:0]  waddr;
  logic [7:0]  wdata;

  assign fall        = e_q & ~e;
  assign short_pulse = hi_cnt < D_250ns;
  assign busy        = (state != ST_IDLE);
  assign busy_limit  = long_delay ? D_1640us : D_40us;

  assign display_on = mode.display_on;
  assign cursor_on  = mode.cursor_on;
  assign blink_on   = mode.blink_on;
  assign two_line   = mode.two_line;
  assign eight_bit  = mode.eight_bit;
  assign inc_mode   = mode.inc_mode;

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state          <= ST_IDLE;
      e_q            <= 1'b0;
      hi_cnt         <= '0;
      cnt            <= '0;
      ac             <= '0;
      mode           <= MODE_RESET;
      protocol_error <= 1'b0;
      cmd_rs         <= 1'b0;
      cmd_d          <= '0;
      long_delay     <= 1'b0;
    end else begin
      state          <= state_n;
      e_q            <= e;
      hi_cnt         <= e ? (short_pulse ? hi_cnt + 32'd1 : hi_cnt) : '0;
      cnt            <= cnt_n;
      ac             <= ac_n;
      mode           <= mode_n;
      protocol_error <= err_n;
      cmd_rs         <= cmd_rs_n;
      cmd_d          <= cmd_d_n;
      long_delay     <= long_delay_n;
    end
  end

  // EXEC counts as the first busy cycle, so BUSY exits at cnt == delay
  // giving delay+1 busy cycles after the edge.
  always_comb begin
    state_n      = state;
    mode_n       = mode;
    ac_n         = ac;
    err_n        = protocol_error;
    cnt_n        = cnt;
    cmd_rs_n     = cmd_rs;
    cmd_d_n      = cmd_d;
    long_delay_n = long_delay;
    we           = 1'b0;
    waddr        = ac;
    wdata        = cmd_d;

    if (fall && short_pulse) err_n = 1'b1;
    if (fall && state != ST_IDLE) err_n = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n  = ST_EXEC;
          cmd_rs_n = rs;
          cmd_d_n  = d;
          cnt_n    = '0;
        end
      end
      ST_EXEC: begin
        state_n      = ST_BUSY;
        long_delay_n = 1'b0;
        cnt_n        = cnt + 32'd1;
        if (cmd_rs) begin
          we   = 1'b1;
          ac_n = ac_step(ac, mode.inc_mode);
        end else if (|(cmd_d & OP_SET_DDRAM)) begin
          if (addr_valid(cmd_d[6:0])) ac_n = cmd_d[6:0];
          else err_n = 1'b1;
        end else if (|(cmd_d & OP_SET_CGRAM)) begin
          // CGRAM is not modelled; only the busy time applies.
        end else if (|(cmd_d & OP_FUNCTION_SET)) begin
          mode_n.eight_bit = cmd_d[4];
          mode_n.two_line  = cmd_d[3];
        end else if (|(cmd_d & OP_SHIFT)) begin
          if (!cmd_d[3]) ac_n = ac_step(ac, cmd_d[2]);
        end else if (|(cmd_d & OP_DISPLAY_CTRL)) begin
          mode_n.display_on = cmd_d[2];
          mode_n.cursor_on  = cmd_d[1];
          mode_n.blink_on   = cmd_d[0];
        end else if (|(cmd_d & OP_ENTRY_MODE)) begin
          mode_n.inc_mode = cmd_d[1];
        end else if (|(cmd_d & OP_HOME)) begin
          ac_n         = '0;
          long_delay_n = 1'b1;
        end else if (|(cmd_d & OP_CLEAR)) begin
          state_n = ST_CLEAR;
          cnt_n   = '0;
        end
      end
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = clear_addr(cnt[6:0]);
        wdata = BLANK_CHAR;
        if (cnt == 32'(VISIBLE_CELLS) - 32'd1) begin
          state_n         = ST_BUSY;
          cnt_n           = '0;
          ac_n            = '0;
          mode_n.inc_mode = 1'b1;
          long_delay_n    = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      ST_BUSY: begin
        if (cnt == busy_limit) state_n = ST_IDLE;
        else cnt_n = cnt + 32'd1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (internal_reset) we = 1'b0;
  end

  lcd_ddram u_ddram (
    .clock   (clock),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_lcd_responder.sv
// Directed plus randomized bench for lcd_responder against an 80-cell ring reference model.
module tb_lcd_responder;

  localparam int unsigned T_E    = 25;
  localparam int unsigned T40    = 40;
  localparam int unsigned T1640  = 120;
  localparam int unsigned BOUND  = 1000;

  logic       clock = 1'b0;
  logic       internal_reset = 1'b1;
  logic       rs = 1'b0;
  logic       e = 1'b0;
  logic [7:0] d = '0;
  logic [6:0] rd_addr = '0;
  logic       busy, display_on, cursor_on, blink_on, two_line, eight_bit, inc_mode;
  logic       protocol_error;
  logic [6:0] ac;
  logic [7:0] rd_data;

  lcd_responder #(.CLK_FREQ(100_000_000), .D_40us(T40), .D_1640us(T1640)) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .rs             (rs),
    .e              (e),
    .d              (d),
    .busy           (busy),
    .ac             (ac),
    .display_on     (display_on),
    .cursor_on      (cursor_on),
    .blink_on       (blink_on),
    .two_line       (two_line),
    .eight_bit      (eight_bit),
    .inc_mode       (inc_mode),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] m_mem [0:127];
  logic [6:0] m_ac;
  logic       m_disp, m_cur, m_blink, m_two, m_eight, m_inc, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference addresses as positions 0..79 on a ring, line 1 following line 0.
  function automatic int lin(input logic [6:0] a);
    return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
  endfunction

  function automatic logic [6:0] addr_of(input int pos);
    return (pos < 40) ? 7'(pos) : 7'(pos - 40 + 64);
  endfunction

  function automatic logic is_valid(input logic [6:0] a);
    return (a < 7'd40) || (a >= 7'd64 && a < 7'd104);
  endfunction

  function automatic logic [6:0] step(input logic [6:0] a, input logic up);
    return addr_of((lin(a) + (up ? 1 : 79)) % 80);
  endfunction

  task automatic model_reset();
    m_ac = '0; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0; m_eight = 1; m_inc = 1; m_err = 0;
  endtask

  // Returns the expected busy length, or -1 when only termination is checked.
  task automatic model_apply(input logic r, input logic [7:0] v, input int unsigned high,
                             output int len);
    int msb;
    len = T40 + 1;
    if (high < T_E) m_err = 1;
    if (r) begin
      m_mem[m_ac] = v;
      m_ac = step(m_ac, m_inc);
      return;
    end
    msb = -1;
    for (int i = 0; i < 8; i++) if (v[i]) msb = i;
    case (msb)
      7: if (is_valid(v[6:0])) m_ac = v[6:0]; else m_err = 1;
      5: begin m_eight = v[4]; m_two = v[3]; end
      4: if (!v[3]) m_ac = step(m_ac, v[2]);
      3: begin m_disp = v[2]; m_cur = v[1]; m_blink = v[0]; end
      2: m_inc = v[1];
      1: begin m_ac = '0; len = T1640 + 1; end
      0: begin
        for (int p = 0; p < 80; p++) m_mem[addr_of(p)] = 8'h20;
        m_ac = '0; m_inc = 1; len = -1;
      end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"}, ac, m_ac);
    check({tag, "_err"}, protocol_error, m_err);
    check({tag, "_mode"}, {display_on, cursor_on, blink_on, two_line, eight_bit, inc_mode},
          {m_disp, m_cur, m_blink, m_two, m_eight, m_inc});
  endtask

  task automatic pulse(input logic r, input logic [7:0] v, input int unsigned high);
    @(negedge clock);
    rs = r; d = v; e = 1'b1;
    repeat (high) @(negedge clock);
    e = 1'b0;
  endtask

  task automatic measure(input int len);
    int n = 0;
    @(posedge clock); #1;
    while (busy && n < BOUND) begin
      n++;
      @(posedge clock); #1;
    end
    if (len >= 0) check("busy_len", n, len);
    else check("busy_drop", busy, 1'b0);
  endtask

  task automatic xfer(input logic r, input logic [7:0] v, input int unsigned high);
    int len;
    model_apply(r, v, high, len);
    pulse(r, v, high);
    measure(len);
    check_state("xfer");
  endtask

  task automatic check_cell(input logic [6:0] a, input logic [7:0] exp);
    @(negedge clock);
    rd_addr = a;
    @(posedge clock); #1;
    check("cell", rd_data, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    internal_reset = 1'b1; e = 1'b0;
    @(negedge clock);
    internal_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic       r;
    int unsigned h;

    model_reset();
    repeat (3) @(negedge clock);
    internal_reset = 1'b0;
    #1;
    check_state("reset");
    check("reset_busy", busy, 1'b0);

    // Driver initialisation sequence
    xfer(0, 8'h30, 30); xfer(0, 8'h30, 30); xfer(0, 8'h30, 30);
    xfer(0, 8'h38, 30); xfer(0, 8'h08, 30); xfer(0, 8'h01, 30);
    xfer(0, 8'h06, 30); xfer(0, 8'h0C, 30);
    check("init_mode", {display_on, two_line, eight_bit, inc_mode}, 4'hF);
    for (int p = 0; p < 80; p++) check_cell(addr_of(p), 8'h20);

    // Line 0 end wraps to line 1 start
    xfer(0, 8'hA7, 30);
    xfer(1, 8'h41, 30);
    check_cell(7'h27, 8'h41);

    // Decrement from 0x00 wraps to 0x67
    xfer(0, 8'h01, 30);
    xfer(0, 8'h04, 30);
    xfer(1, 8'h5A, 30);
    check_cell(7'h00, 8'h5A);
    xfer(0, 8'h06, 30);

    // Short E pulse still writes
    do_reset();
    xfer(0, 8'h85, 30);
    xfer(1, 8'h33, 10);
    check_cell(7'h05, 8'h33);

    // Set address into the hole is ignored
    do_reset();
    xfer(0, 8'h92, 30);
    xfer(0, 8'hB0, 30);

    // Transfer during clear is ignored
    do_reset();
    begin
      int len;
      model_apply(0, 8'h01, 30, len);
      pulse(0, 8'h01, 30);
      repeat (5) @(negedge clock);
      pulse(1, 8'h55, 30);
      m_err = 1;
      measure(-1);
      check_state("busy_ignore");
      check_cell(7'h00, 8'h20);
      check_cell(7'h01, 8'h20);
    end

    // Randomized transfers
    do_reset();
    for (int k = 0; k < 60; k++) begin
      r = 1'b0;
      case ($urandom_range(0, 7))
        0, 1: begin r = 1'b1; v = 8'($urandom_range(0, 255)); end
        2: v = 8'h80 | 8'($urandom_range(0, 127));
        3: v = 8'h04 | 8'($urandom_range(0, 3));
        4: v = 8'h10 | 8'($urandom_range(0, 15));
        5: v = 8'h08 | 8'($urandom_range(0, 7));
        6: v = 8'h20 | 8'($urandom_range(0, 31));
        default: v = ($urandom_range(0, 1) == 0) ? 8'h02 : (8'h40 | 8'($urandom_range(0, 63)));
      endcase
      h = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 24) : 30;
      xfer(r, v, h);
    end
    for (int p = 0; p < 80; p++) check_cell(addr_of(p), m_mem[addr_of(p)]);

    // Reset in the middle of a clear
    do_reset();
    xfer(0, 8'h80, 30);
    for (int i = 0; i < 6; i++) xfer(1, 8'h61 + 8'(i), 30);
    xfer(0, 8'hC5, 30); xfer(1, 8'h77, 30);
    xfer(0, 8'hE0, 30); xfer(1, 8'h66, 30);
    pulse(0, 8'h01, 30);
    repeat (20) @(posedge clock);
    @(negedge clock);
    internal_reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    check("mid_clear_busy", busy, 1'b0);
    check_state("mid_clear");
    @(negedge clock);
    internal_reset = 1'b0;
    for (int i = 0; i < 6; i++) check_cell(7'(i), 8'h20);
    check_cell(7'h45, 8'h77);
    check_cell(7'h60, 8'h66);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
